inv_mix_columns_iter: RTL and testbench

- Iterative AES InvMixColumns engine for the decrypt datapath; the inverse counterpart of the combinational MixColumns stage.
- Accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Presents the registered result over a valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the round-iterative decryptor.

---
 rtl/inv_mix_columns_iter.sv | 194 +++++++++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
//   Iterative AES InvMixColumns engine for the round-iterative decryptor.
//   A 128-bit state is accepted over a valid/ready handshake, transformed
//   COLS_PER_CYCLE columns per clock (column order 0,1,2,3), and the
//   registered result is presented over a valid/ready handshake.
//
//   State layout: column c is bits [c*32 +: 32]; within a column row 0 is the
//   most significant byte and row 3 the least significant byte.
//
// Parameters
//   DATA_W          state width (only 128 is supported)
//   COLS_PER_CYCLE  columns transformed per BUSY cycle (1, 2 or 4)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block can accept in_data this cycle
//   in_data    state to transform
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts out_data
//   out_data   InvMixColumns(in_data), registered
// ---------------------------------------------------------------------------
module inv_mix_columns_iter #(
  parameter int DATA_W         = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  // Elaboration-time guards on the parameter set.
  if (DATA_W != 128) begin : g_bad_width
    $error("inv_mix_columns_iter: DATA_W must be 128");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // GF(2^8) helpers (mod x^8 + x^4 + x^3 + x + 1)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One InvMixColumns column; row 0 sits in the top byte.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    r1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    r2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    r3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    return {r0, r1, r2, r3};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state, state_next;
  logic [2:0]          cnt;          // next column to transform (0..4)
  logic [DATA_W-1:0]   work;         // captured input state
  logic [DATA_W-1:0]   res;          // result columns as they are produced
  logic                accept;
  logic                last_group;

  logic [1:0]          col_idx [COLS_PER_CYCLE];
  logic [31:0]         col_in  [COLS_PER_CYCLE];
  logic [31:0]         col_out [COLS_PER_CYCLE];

  // The group ending at column 3 is the last one; cnt is one bit wider than
  // a column index so that cnt + COLS_PER_CYCLE can reach 4 without wrapping.
  assign last_group = (cnt + 3'(COLS_PER_CYCLE)) == 3'd4;
  assign accept     = in_valid & in_ready;
  assign out_data   = res;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_group) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Freeing the output slot also frees the input side this cycle.
          in_ready   = 1'b1;
          state_next = in_valid ? BUSY : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Column datapath: pick the current group of columns from the work register
  // -------------------------------------------------------------------------
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx[g] = cnt[1:0] + 2'(g);
      col_in[g]  = work[{col_idx[g], 5'b0} +: 32];
      col_out[g] = inv_col(col_in[g]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: work and result registers are reset too, because out_data must
      // read as zero after reset rather than leaking the aborted block.
      cnt  <= '0;
      work <= '0;
      res  <= '0;
    end else if (accept) begin
      work <= in_data;
      cnt  <= '0;
    end else if (state == BUSY) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        res[{col_idx[g], 5'b0} +: 32] <= col_out[g];
      end
      cnt <= cnt + 3'(COLS_PER_CYCLE);
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_iter
//   Directed bench for inv_mix_columns_iter. Three instances (1, 2 and 4
//   columns per cycle) share the input-side stimulus; most checks look at
//   the one-column instance, the latency sweep looks at all three.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] R2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         in_ready1, in_ready2, in_ready4;
  logic         out_valid1, out_valid2, out_valid4;
  logic [127:0] out_data1, out_data2, out_data4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.DATA_W(128), .COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1));

  inv_mix_columns_iter #(.DATA_W(128), .COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2));

  inv_mix_columns_iter #(.DATA_W(128), .COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4));

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs and samples both
  // happen here, well away from the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward MixColumns reference, used to build round-trip vectors.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c*32+24 +: 8];
      a1 = s[c*32+16 +: 8];
      a2 = s[c*32+8  +: 8];
      a3 = s[c*32    +: 8];
      r[c*32+24 +: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
      r[c*32+16 +: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
      r[c*32+8  +: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
      r[c*32    +: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  // Offer one block to dut1 from IDLE, then wait (bounded) for its result.
  // lat counts edges after the accept edge until out_valid is seen.
  task automatic send_block(input logic [127:0] d, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;   // post-accept changes must be ignored
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid1) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           lat;
    int           seen;
    logic [127:0] s;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", out_valid1, 1'b0);
    check("rst_out_data",  out_data1,  '0);
    check("rst_in_ready",  in_ready1,  1'b1);
    rst = 1'b0;
    tick();

    // First vector on all three widths: latency 4 / 2 / 1 and identical data
    in_data  = V1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("lat1_valid_k%0d", k), out_valid1, (k == 4));
      check($sformatf("lat2_valid_k%0d", k), out_valid2, (k == 2));
      check($sformatf("lat4_valid_k%0d", k), out_valid4, (k == 1));
      if (k == 1) check("v1_data_cpc4", out_data4, R1);
      if (k == 2) check("v1_data_cpc2", out_data2, R1);
      if (k == 3) check("busy_in_ready", in_ready1, 1'b0);
      if (k == 4) check("v1_data_cpc1", out_data1, R1);
    end
    tick();
    check("v1_back_idle", out_valid1, 1'b0);

    // Second vector
    send_block(V2, lat);
    check("v2_latency", 128'(lat), 128'd4);
    check("v2_data",    out_data1, R2);
    tick();

    // Round trip through the forward model
    for (int i = 0; i < 3; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send_block(mix_model(s), lat);
      check($sformatf("roundtrip_%0d", i), out_data1, s);
      tick();
    end

    // Backpressure: hold out_ready low for 10 cycles after out_valid
    out_ready = 1'b0;
    send_block(V1, lat);
    check("bp_latency", 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp_valid_%0d", k),    out_valid1, 1'b1);
      check($sformatf("bp_data_%0d", k),     out_data1,  R1);
      check($sformatf("bp_in_ready_%0d", k), in_ready1,  1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready1, 1'b1);
    tick();
    check("bp_handshake_done", out_valid1, 1'b0);
    tick();

    // Back-to-back: second accept on the first output handshake edge
    in_data  = V1;
    in_valid = 1'b1;
    tick();
    in_data  = V2;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid1) break;
    end
    check("b2b_first_latency", 128'(lat), 128'd4);
    check("b2b_first_data",    out_data1, R1);
    check("b2b_in_ready",      in_ready1, 1'b1);
    tick();
    in_valid = 1'b0;
    check("b2b_busy_again", out_valid1, 1'b0);
    lat = 1;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid1) break;
    end
    check("b2b_spacing",     128'(lat), 128'd5);
    check("b2b_second_data", out_data1, R2);
    tick();
    tick();
    tick();

    // Reset mid-operation: resynchronise, accept, reset two cycles later
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    in_data  = V2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid1, 1'b0);
    check("abort_out_data",  out_data1,  '0);
    check("abort_in_ready",  in_ready1,  1'b1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid1) seen++;
    end
    check("abort_no_stale", 128'(seen), 128'd0);
    check("abort_data_zero", out_data1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
